shift_add_multiplier: RTL

Sequential radix-2 shift-add multiplier for the RV32M multiply group (mul, mulh, mulhsu, mulhu). It sits in the EXE stage beside the iterative divider and uses the same enable/response handshake, so the M-extension stall logic treats both units identically. The block captures operands and funct3 once, iterates one bit per cycle, and holds a registered 32-bit result with a one-cycle response pulse.

---
 rtl/rv32i_types.sv | 17 +
 rtl/shift_add_multiplier.sv | 119 +++++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// Shared RV32 M-extension types: funct3 op select and the multiplier state encoding.
package rv32i_types;

    typedef enum logic [1:0] {
        M_MUL    = 2'b00,
        M_MULH   = 2'b01,
        M_MULHSU = 2'b10,
        M_MULHU  = 2'b11
    } m_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add multiplier for mul/mulh/mulhsu/mulhu: magnitudes are multiplied
// one bit per cycle and the sign is applied once on the way into the result register.
module shift_add_multiplier
    import rv32i_types::*;
#(
    parameter int XLEN          = 32,
    parameter bit ZERO_SHORTCUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_enable,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] f,
    output logic            mul_resp,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    mul_state_t          state_q, state_d;
    m_funct3_t           op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [XLEN-1:0]     f_q, f_d;

    m_funct3_t           op_in;
    logic                a_sgn, b_sgn;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       add_w;
    logic [2*XLEN-1:0]   prod_step, prod_final;
    logic                unused_funct3;

    assign unused_funct3 = funct3[2];

    // Operand prep: an operand is only negated when its op treats it as signed.
    always_comb begin
        op_in = m_funct3_t'(funct3[1:0]);
        a_sgn = ((op_in == M_MULH) || (op_in == M_MULHSU)) && a[XLEN-1];
        b_sgn = (op_in == M_MULH) && b[XLEN-1];
        a_mag = a_sgn ? (~a + XLEN'(1)) : a;
        b_mag = b_sgn ? (~b + XLEN'(1)) : b;
    end

    // One iteration: conditional add into hi keeping the carry, then shift {carry, hi, lo} right.
    always_comb begin
        add_w      = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step  = {add_w, prod_q[XLEN-1:1]};
        prod_final = neg_q ? (~prod_step + (2*XLEN)'(1)) : prod_step;
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        count_d = count_q;
        f_d     = f_q;
        unique case (state_q)
            IDLE: begin
                if (mul_enable) begin
                    op_d    = op_in;
                    neg_d   = a_sgn ^ b_sgn;
                    mcand_d = a_mag;
                    prod_d  = {{XLEN{1'b0}}, b_mag};
                    count_d = '0;
                    if (ZERO_SHORTCUT && ((a == '0) || (b == '0))) begin
                        f_d     = '0;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prod_d  = prod_step;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    f_d     = (op_q == M_MUL) ? prod_final[XLEN-1:0] : prod_final[2*XLEN-1:XLEN];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= M_MUL;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            count_q <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            count_q <= count_d;
            f_q     <= f_d;
        end
    end

    assign f        = f_q;
    assign mul_resp = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule
